memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/memory_stage_if.sv | 27 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/memory_stage.sv | 180 ++++++++++++++++++
 tb/tb_memory_stage.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-stage definitions: funct3 load/store codes, result-source
// encoding, memory-stage FSM states and the access-alignment helper.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_t;

  // Byte accesses never misalign; halfwords need addr[0]=0; everything else is a word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the
// data memory (slave).
interface memory_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                  o_dmem_req;
  logic                  o_dmem_we;
  logic [ADDR_WIDTH-1:0] o_dmem_addr;
  logic [3:0]            o_dmem_be;
  logic [DATA_WIDTH-1:0] o_dmem_wdata;
  logic                  i_dmem_gnt;
  logic                  i_dmem_rvalid;
  logic [DATA_WIDTH-1:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
    output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Load/store lane steering: byte enables and replicated store data, plus
// sign/zero extension of load data, selected by funct3 and address low bits.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      f3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] load_data_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: narrow stores replicate across lanes, byte enables pick the lane.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (f3_i)
      F3_SB: begin
        be_o    = 4'(4'b0001 << addr_lo_i);
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_SH: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    ld_byte = load_data_i[7:0];
      2'd1:    ld_byte = load_data_i[15:8];
      2'd2:    ld_byte = load_data_i[23:16];
      default: ld_byte = load_data_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];
  end

  // Unknown load funct3 codes fall back to a full word.
  always_comb begin
    case (f3_i)
      F3_LB:   rdata_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  rdata_o = {24'd0, ld_byte};
      F3_LH:   rdata_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  rdata_o = {16'd0, ld_half};
      default: rdata_o = load_data_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RISC-V memory stage: data-memory handshake FSM, pipeline stall, MEM/WB register.
// Optional MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of masking.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_alu_result_m,
  input  logic [DATA_WIDTH-1:0] i_write_data_m,
  input  logic                  i_regwrite_m,
  input  logic                  i_memwrite_m,
  input  logic [1:0]            i_resultsrc_m,
  input  logic [4:0]            i_rd_addr_m,
  input  logic [ADDR_WIDTH-1:0] i_pc4_m,
  input  logic [2:0]            i_f3_m,
  memory_stage_if.master        dmem,
  output logic                  o_stall_m,
  output logic [DATA_WIDTH-1:0] o_forward_m,
  output logic                  o_misaligned_m,
  output logic                  o_regwrite_w,
  output logic [1:0]            o_resultsrc_w,
  output logic [4:0]            o_rd_addr_w,
  output logic [DATA_WIDTH-1:0] o_alu_result_w,
  output logic [DATA_WIDTH-1:0] o_read_data_w,
  output logic [ADDR_WIDTH-1:0] o_pc4_w
);

  mem_state_t state_q, state_d;

  logic                  is_load_c;
  logic                  pending_c;
  logic                  misaligned_c;
  logic                  req_c;
  logic                  stall_c;
  logic                  hold_en_c;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] load_data_c;

  logic                  hold_we_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [3:0]            hold_be_q;
  logic [DATA_WIDTH-1:0] hold_wdata_q;

  logic                  regwrite_q;
  logic [1:0]            resultsrc_q;
  logic [4:0]            rd_addr_q;
  logic [DATA_WIDTH-1:0] alu_result_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic [ADDR_WIDTH-1:0] pc4_q;

  assign is_load_c = (i_resultsrc_m == RES_LOAD);
  assign pending_c = i_memwrite_m | is_load_c;

`ifdef MISALIGN_TRAP_EN
  assign misaligned_c = (state_q == IDLE) & pending_c & ~i_rst
                      & is_misaligned(i_f3_m, i_alu_result_m[1:0]);
`else
  assign misaligned_c = 1'b0;
`endif

  lsu_align u_lsu_align (
    .f3_i         (i_f3_m),
    .addr_lo_i    (i_alu_result_m[1:0]),
    .store_data_i (i_write_data_m),
    .load_data_i  (dmem.i_dmem_rdata),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .rdata_o      (load_data_c)
  );

  // Handshake FSM: stall every cycle until the access completes.
  always_comb begin
    state_d   = state_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    hold_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_c && !misaligned_c) begin
          req_c = 1'b1;
          if (dmem.i_dmem_gnt) begin
            if (is_load_c) begin
              state_d = WAIT_RSP;
              stall_c = 1'b1;
            end
          end else begin
            state_d   = REQ;
            stall_c   = 1'b1;
            hold_en_c = 1'b1;
          end
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (dmem.i_dmem_gnt) begin
          if (hold_we_q) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_RSP;
            stall_c = 1'b1;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (dmem.i_dmem_rvalid) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Freeze the request payload while waiting for a grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
    end else if (hold_en_c) begin
      hold_we_q    <= i_memwrite_m;
      hold_addr_q  <= i_alu_result_m[ADDR_WIDTH+1:2];
      hold_be_q    <= be_c;
      hold_wdata_q <= wdata_c;
    end
  end

  assign dmem.o_dmem_req   = req_c & ~i_rst;
  assign dmem.o_dmem_we    = (state_q == REQ) ? hold_we_q    : i_memwrite_m;
  assign dmem.o_dmem_addr  = (state_q == REQ) ? hold_addr_q  : i_alu_result_m[ADDR_WIDTH+1:2];
  assign dmem.o_dmem_be    = (state_q == REQ) ? hold_be_q    : be_c;
  assign dmem.o_dmem_wdata = (state_q == REQ) ? hold_wdata_q : wdata_c;

  assign o_stall_m      = stall_c & ~i_rst;
  assign o_forward_m    = i_alu_result_m;
  assign o_misaligned_m = misaligned_c;

  // MEM/WB register: a stall or trapped access inserts a bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regwrite_q   <= 1'b0;
      resultsrc_q  <= '0;
      rd_addr_q    <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc4_q        <= '0;
    end else begin
      regwrite_q   <= i_regwrite_m & ~stall_c & ~misaligned_c;
      resultsrc_q  <= i_resultsrc_m;
      rd_addr_q    <= i_rd_addr_m;
      alu_result_q <= i_alu_result_m;
      read_data_q  <= (state_q == WAIT_RSP) ? load_data_c : '0;
      pc4_q        <= i_pc4_m;
    end
  end

  assign o_regwrite_w   = regwrite_q;
  assign o_resultsrc_w  = resultsrc_q;
  assign o_rd_addr_w    = rd_addr_q;
  assign o_alu_result_w = alu_result_q;
  assign o_read_data_w  = read_data_q;
  assign o_pc4_w        = pc4_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: stores, loads, stalls, reset
// mid-transaction and alignment handling (both MISALIGN_TRAP_EN builds).
module tb_memory_stage;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 10;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic [DATA_WIDTH-1:0] i_alu_result_m;
  logic [DATA_WIDTH-1:0] i_write_data_m;
  logic                  i_regwrite_m;
  logic                  i_memwrite_m;
  logic [1:0]            i_resultsrc_m;
  logic [4:0]            i_rd_addr_m;
  logic [ADDR_WIDTH-1:0] i_pc4_m;
  logic [2:0]            i_f3_m;
  logic                  o_stall_m;
  logic [DATA_WIDTH-1:0] o_forward_m;
  logic                  o_misaligned_m;
  logic                  o_regwrite_w;
  logic [1:0]            o_resultsrc_w;
  logic [4:0]            o_rd_addr_w;
  logic [DATA_WIDTH-1:0] o_alu_result_w;
  logic [DATA_WIDTH-1:0] o_read_data_w;
  logic [ADDR_WIDTH-1:0] o_pc4_w;

  int n_cmp = 0;
  int n_err = 0;

  memory_stage_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dmem_if ();

  memory_stage #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_alu_result_m (i_alu_result_m),
    .i_write_data_m (i_write_data_m),
    .i_regwrite_m   (i_regwrite_m),
    .i_memwrite_m   (i_memwrite_m),
    .i_resultsrc_m  (i_resultsrc_m),
    .i_rd_addr_m    (i_rd_addr_m),
    .i_pc4_m        (i_pc4_m),
    .i_f3_m         (i_f3_m),
    .dmem           (dmem_if),
    .o_stall_m      (o_stall_m),
    .o_forward_m    (o_forward_m),
    .o_misaligned_m (o_misaligned_m),
    .o_regwrite_w   (o_regwrite_w),
    .o_resultsrc_w  (o_resultsrc_w),
    .o_rd_addr_w    (o_rd_addr_w),
    .o_alu_result_w (o_alu_result_w),
    .o_read_data_w  (o_read_data_w),
    .o_pc4_w        (o_pc4_w)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_alu_result_m        = '0;
    i_write_data_m        = '0;
    i_regwrite_m          = 1'b0;
    i_memwrite_m          = 1'b0;
    i_resultsrc_m         = 2'b00;
    i_rd_addr_m           = '0;
    i_pc4_m               = '0;
    i_f3_m                = '0;
    dmem_if.i_dmem_gnt    = 1'b0;
    dmem_if.i_dmem_rvalid = 1'b0;
    dmem_if.i_dmem_rdata  = '0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
    i_alu_result_m = addr;
    i_f3_m         = f3;
    i_resultsrc_m  = 2'b01;
    i_regwrite_m   = 1'b1;
    i_rd_addr_m    = rd;
  endtask

  // Store vectors: f3, byte address, data, expected be, expected wdata
  logic [2:0]  st_f3   [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
  logic [31:0] st_addr [4] = '{32'h6, 32'h2, 32'h10, 32'h103};
  logic [31:0] st_data [4] = '{32'h0000_00AB, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_005A};
  logic [3:0]  st_be   [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b1000};
  logic [31:0] st_wd   [4] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF, 32'h5A5A_5A5A};

  // Load vectors: f3, byte address, memory word, expected extracted value
  logic [2:0]  ld_f3   [6] = '{3'b100, 3'b000, 3'b101, 3'b010, 3'b011, 3'b000};
  logic [31:0] ld_addr [6] = '{32'h3, 32'h1, 32'h0, 32'h8, 32'h4, 32'h2};
  logic [31:0] ld_mem  [6] = '{32'hF000_0000, 32'h0000_8000, 32'h0000_ABCD,
                               32'h1234_5678, 32'hCAFE_F00D, 32'h007F_0000};
  logic [31:0] ld_exp  [6] = '{32'h0000_00F0, 32'hFFFF_FF80, 32'h0000_ABCD,
                               32'h1234_5678, 32'hCAFE_F00D, 32'h0000_007F};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_cnt;
    i_rst = 1'b1;
    clear_inputs();
    i_memwrite_m = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_req", 64'(dmem_if.o_dmem_req), 64'd0);
    check_eq("rst_stall", 64'(o_stall_m), 64'd0);
    check_eq("rst_misal", 64'(o_misaligned_m), 64'd0);
    check_eq("rst_regwrite_w", 64'(o_regwrite_w), 64'd0);
    check_eq("rst_alu_w", 64'(o_alu_result_w), 64'd0);
    clear_inputs();
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // ALU result passes straight through to writeback
    i_alu_result_m = 32'h1234;
    i_regwrite_m   = 1'b1;
    i_rd_addr_m    = 5'd5;
    i_pc4_m        = 10'h10;
    #1;
    check_eq("alu_stall", 64'(o_stall_m), 64'd0);
    check_eq("alu_req", 64'(dmem_if.o_dmem_req), 64'd0);
    check_eq("alu_fwd", 64'(o_forward_m), 64'h1234);
    tick();
    check_eq("alu_regwrite_w", 64'(o_regwrite_w), 64'd1);
    check_eq("alu_rd_w", 64'(o_rd_addr_w), 64'd5);
    check_eq("alu_result_w", 64'(o_alu_result_w), 64'h1234);
    check_eq("alu_pc4_w", 64'(o_pc4_w), 64'h10);
    clear_inputs();

    // Stores granted in the request cycle: zero stall
    for (int i = 0; i < 4; i++) begin
      i_alu_result_m     = st_addr[i];
      i_write_data_m     = st_data[i];
      i_f3_m             = st_f3[i];
      i_memwrite_m       = 1'b1;
      dmem_if.i_dmem_gnt = 1'b1;
      #1;
      check_eq($sformatf("st%0d_req", i), 64'(dmem_if.o_dmem_req), 64'd1);
      check_eq($sformatf("st%0d_we", i), 64'(dmem_if.o_dmem_we), 64'd1);
      check_eq($sformatf("st%0d_addr", i), 64'(dmem_if.o_dmem_addr), 64'(st_addr[i] >> 2));
      check_eq($sformatf("st%0d_be", i), 64'(dmem_if.o_dmem_be), 64'(st_be[i]));
      check_eq($sformatf("st%0d_wdata", i), 64'(dmem_if.o_dmem_wdata), 64'(st_wd[i]));
      check_eq($sformatf("st%0d_stall", i), 64'(o_stall_m), 64'd0);
      tick();
      clear_inputs();
    end

    // Loads granted immediately, response one cycle later
    for (int i = 0; i < 6; i++) begin
      drive_load(ld_addr[i], ld_f3[i], 5'(i + 8));
      dmem_if.i_dmem_gnt = 1'b1;
      #1;
      check_eq($sformatf("ld%0d_req", i), 64'(dmem_if.o_dmem_req), 64'd1);
      check_eq($sformatf("ld%0d_stall_gnt", i), 64'(o_stall_m), 64'd1);
      tick();
      check_eq($sformatf("ld%0d_bubble", i), 64'(o_regwrite_w), 64'd0);
      dmem_if.i_dmem_gnt    = 1'b0;
      dmem_if.i_dmem_rvalid = 1'b1;
      dmem_if.i_dmem_rdata  = ld_mem[i];
      #1;
      check_eq($sformatf("ld%0d_stall_rsp", i), 64'(o_stall_m), 64'd0);
      tick();
      check_eq($sformatf("ld%0d_rdata_w", i), 64'(o_read_data_w), 64'(ld_exp[i]));
      check_eq($sformatf("ld%0d_regwrite_w", i), 64'(o_regwrite_w), 64'd1);
      check_eq($sformatf("ld%0d_rd_w", i), 64'(o_rd_addr_w), 64'(i + 8));
      clear_inputs();
    end

    // lh with grant delayed two cycles: three stall cycles
    stall_cnt = 0;
    drive_load(32'h2, 3'b001, 5'd7);
    #1;
    check_eq("lh_req_c0", 64'(dmem_if.o_dmem_req), 64'd1);
    stall_cnt += int'(o_stall_m);
    tick();
    check_eq("lh_bubble_c1", 64'(o_regwrite_w), 64'd0);
    check_eq("lh_req_c1", 64'(dmem_if.o_dmem_req), 64'd1);
    stall_cnt += int'(o_stall_m);
    tick();
    dmem_if.i_dmem_gnt = 1'b1;
    #1;
    check_eq("lh_req_c2", 64'(dmem_if.o_dmem_req), 64'd1);
    check_eq("lh_addr_c2", 64'(dmem_if.o_dmem_addr), 64'd0);
    stall_cnt += int'(o_stall_m);
    tick();
    dmem_if.i_dmem_gnt    = 1'b0;
    dmem_if.i_dmem_rvalid = 1'b1;
    dmem_if.i_dmem_rdata  = 32'h8001_0000;
    #1;
    check_eq("lh_req_c3", 64'(dmem_if.o_dmem_req), 64'd0);
    stall_cnt += int'(o_stall_m);
    tick();
    check_eq("lh_stall_cycles", 64'(stall_cnt), 64'd3);
    check_eq("lh_rdata_w", 64'(o_read_data_w), 64'hFFFF_8001);
    check_eq("lh_regwrite_w", 64'(o_regwrite_w), 64'd1);
    clear_inputs();

    // Grant and response with no request outstanding are ignored
    dmem_if.i_dmem_gnt    = 1'b1;
    dmem_if.i_dmem_rvalid = 1'b1;
    dmem_if.i_dmem_rdata  = 32'h5555_AAAA;
    #1;
    check_eq("stray_req", 64'(dmem_if.o_dmem_req), 64'd0);
    check_eq("stray_stall", 64'(o_stall_m), 64'd0);
    tick();
    check_eq("stray_rdata_w", 64'(o_read_data_w), 64'd0);
    clear_inputs();

    // Reset while waiting for the response, then a late response arrives
    drive_load(32'h4, 3'b010, 5'd3);
    i_pc4_m            = 10'h2C;
    dmem_if.i_dmem_gnt = 1'b1;
    tick();
    dmem_if.i_dmem_gnt = 1'b0;
    #1;
    check_eq("rstw_stall_wait", 64'(o_stall_m), 64'd1);
    tick();
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("rstw_stall", 64'(o_stall_m), 64'd0);
    check_eq("rstw_req", 64'(dmem_if.o_dmem_req), 64'd0);
    check_eq("rstw_alu_w", 64'(o_alu_result_w), 64'd0);
    check_eq("rstw_pc4_w", 64'(o_pc4_w), 64'd0);
    clear_inputs();
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    dmem_if.i_dmem_rvalid = 1'b1;
    dmem_if.i_dmem_rdata  = 32'hFFFF_FFFF;
    #1;
    check_eq("late_rsp_stall", 64'(o_stall_m), 64'd0);
    tick();
    check_eq("late_rsp_rdata_w", 64'(o_read_data_w), 64'd0);
    check_eq("late_rsp_regwrite_w", 64'(o_regwrite_w), 64'd0);
    clear_inputs();

    // Misaligned word load
    drive_load(32'h2, 3'b010, 5'd4);
    dmem_if.i_dmem_gnt = 1'b1;
`ifdef MISALIGN_TRAP_EN
    #1;
    check_eq("mis_flag", 64'(o_misaligned_m), 64'd1);
    check_eq("mis_req", 64'(dmem_if.o_dmem_req), 64'd0);
    check_eq("mis_stall", 64'(o_stall_m), 64'd0);
    tick();
    check_eq("mis_regwrite_w", 64'(o_regwrite_w), 64'd0);
`else
    #1;
    check_eq("mis_flag", 64'(o_misaligned_m), 64'd0);
    check_eq("mis_req", 64'(dmem_if.o_dmem_req), 64'd1);
    check_eq("mis_addr", 64'(dmem_if.o_dmem_addr), 64'd0);
    tick();
    dmem_if.i_dmem_gnt    = 1'b0;
    dmem_if.i_dmem_rvalid = 1'b1;
    dmem_if.i_dmem_rdata  = 32'h1122_3344;
    tick();
    check_eq("mis_rdata_w", 64'(o_read_data_w), 64'h1122_3344);
    check_eq("mis_regwrite_w", 64'(o_regwrite_w), 64'd1);
`endif
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
